// File: rtl/fetch_receive.sv
// fetch_receive
//
// Receive side of the instruction-fetch interface. Instruction memory is read
// synchronously, so the data arriving this cycle belongs to the PC the issue
// stage presented last cycle. This block pairs the two and hands decode a
// stable instruction/PC/valid bundle. It holds an instruction across stalls
// and replaces wrong-path fetches with NOP bubbles after a redirect.
//
// Ports:
//   clock        in   clock, all state updates on posedge
//   reset        in   synchronous, active-high reset
//   i_mem_data   in   read data for the address issued in the previous cycle
//   issue_PC     in   PC presented to instruction memory this cycle
//   stall        in   downstream not accepting; issue stage holds its PC
//   flush        in   redirect taken; issue stage loads its target this edge
//   instruction  out  instruction to decode
//   inst_PC      out  PC of instruction
//   valid        out  instruction is a real fetched instruction
//   scan         in   enables per-cycle debug reporting (simulation only)
//   fetch_count  out  accepted-instruction counter (FETCH_RECEIVE_PERF_EN only)
//
// Optional feature macro: FETCH_RECEIVE_PERF_EN adds the fetch_count port.

module fetch_receive #(
  parameter int                       CORE            = 0,
  parameter int                       DATA_WIDTH      = 32,
  parameter int                       ADDRESS_BITS    = 20,
  parameter logic [ADDRESS_BITS-1:0]  RESET_PC        = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP             = 32'h00000013,
  parameter logic [31:0]              SCAN_CYCLES_MIN = 32'd1,
  parameter logic [31:0]              SCAN_CYCLES_MAX = 32'd1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic                    stall,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    valid,
  input  logic                    scan
`ifdef FETCH_RECEIVE_PERF_EN
  ,
  output logic [31:0]             fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] pc_d1;
  logic [DATA_WIDTH-1:0]   held_instr;
  logic [31:0]             cycle_count;

  // State machine plus the PC/instruction pipeline registers.
  // pc_d1 follows issue_PC whenever the issue stage is advancing (and always
  // during BOOT, so the first real fetch is paired with its PC). On a stall it
  // keeps the PC of the instruction being held. held_instr is only captured on
  // the RUN->HOLD transition, because after that cycle the memory output
  // already reflects the next address and can no longer be trusted.
  // Flush has priority over stall in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= BOOT;
      pc_d1      <= '0;
      held_instr <= NOP;
    end else begin
      if (state == BOOT || !stall) begin
        pc_d1 <= issue_PC;
      end
      case (state)
        BOOT: begin
          state <= flush ? FLUSH : RUN;
        end
        RUN: begin
          if (flush) begin
            state <= FLUSH;
          end else if (stall) begin
            state      <= HOLD;
            held_instr <= i_mem_data;
          end
        end
        HOLD: begin
          if (flush) begin
            state <= FLUSH;
          end else if (!stall) begin
            state <= RUN;
          end
        end
        FLUSH: begin
          state <= flush ? FLUSH : RUN;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Output bundle decoded from state. In RUN the memory data passes straight
  // through so there is no extra cycle of fetch latency.
  always_comb begin
    instruction = NOP;
    inst_PC     = pc_d1;
    valid       = 1'b0;
    case (state)
      BOOT: begin
        inst_PC = RESET_PC;
      end
      RUN: begin
        instruction = i_mem_data;
        valid       = 1'b1;
      end
      HOLD: begin
        instruction = held_instr;
        valid       = 1'b1;
      end
      default: begin
        instruction = NOP;
      end
    endcase
  end

  // Free-running cycle counter that frames the debug reporting window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

`ifdef FETCH_RECEIVE_PERF_EN
  // Counts instructions actually accepted by decode: valid and not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (valid && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Debug trace of the delivered bundle inside the configured cycle window.
  always @(posedge clock) begin
    if (scan && cycle_count >= SCAN_CYCLES_MIN && cycle_count <= SCAN_CYCLES_MAX) begin
      $display("core %0d fetch_receive state=%s inst_PC=%h instruction=%h valid=%b",
               CORE, state.name(), inst_PC, instruction, valid);
    end
  end
`endif

endmodule

// File: doc/fetch_receive.md
# fetch_receive

Receive side of the instruction-fetch interface. Takes the synchronous instruction-memory read data for the address the PC-issue stage presented one cycle earlier and pairs it with that PC. Produces a stable instruction/PC/valid bundle for decode. Holds the instruction across stalls and replaces wrong-path fetches with NOP bubbles after a redirect.

## Interface
Parameters:
- CORE, 0, core index; used only in scan output
- RESET_PC, 0, PC reported while in BOOT
- DATA_WIDTH, 32, instruction width
- ADDRESS_BITS, 20, PC width
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0)
- SCAN_CYCLES_MIN, 1, first cycle of scan reporting window
- SCAN_CYCLES_MAX, 1000, last cycle of scan reporting window

Ports:
- clock  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- i_mem_data  in  DATA_WIDTH  read data for the address issued in the previous cycle
- issue_PC  in  ADDRESS_BITS  PC presented to instruction memory this cycle
- stall  in  1  downstream not accepting; issue stage holds its PC this cycle
- flush  in  1  redirect taken this cycle; issue stage loads target_PC at this edge
- instruction  out  DATA_WIDTH  instruction to decode
- inst_PC  out  ADDRESS_BITS  PC of `instruction`
- valid  out  1  `instruction` is a real fetched instruction
- scan  in  1  enables debug reporting

## Operation
- Register pc_d1 (ADDRESS_BITS) is loaded with issue_PC at each edge when state is BOOT, or when stall=0. Otherwise it holds.
- Register held_instr (DATA_WIDTH) is loaded with i_mem_data at the edge leaving RUN with stall=1 and flush=0.
- States are BOOT, RUN, HOLD and FLUSH. Reset state is BOOT. Flush has priority over stall in every state.
- BOOT:
  - Outputs: instruction=NOP, inst_PC=RESET_PC, valid=0.
  - Next state: flush -> FLUSH, else -> RUN. stall is ignored in BOOT.
- RUN:
  - Outputs: instruction=i_mem_data (combinational pass-through), inst_PC=pc_d1, valid=1.
  - Next state: flush -> FLUSH; stall -> HOLD and capture held_instr; else stay in RUN.
- HOLD:
  - Outputs: instruction=held_instr, inst_PC=pc_d1, valid=1.
  - Next state: flush -> FLUSH; stall -> HOLD; else -> RUN.
- FLUSH:
  - Outputs: instruction=NOP, inst_PC=pc_d1, valid=0.
  - Next state: flush -> FLUSH, else -> RUN.
  - The fetch issued in the flush cycle is wrong-path and is squashed.
- Scan: when scan=1 and the internal cycle counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], the block $displays CORE, state, inst_PC, instruction and valid once per cycle. This is simulation only.
- The internal cycle counter is 32 bits, reset to 0, increments every cycle and wraps.

## Timing
- Reset values: state=BOOT, pc_d1=0, held_instr=NOP, instruction=NOP, inst_PC=RESET_PC, valid=0.
- First cycle with reset=0 is BOOT. The instruction at RESET_PC appears on the next cycle with valid=1.
- Fetch latency: the address on issue_PC in cycle N is delivered in cycle N+1, in the absence of stall/flush.
- Stall asserted in cycle N:
  - Instruction X is visible in N via pass-through.
  - X is held from N+1 until the cycle in which stall deasserts, inclusive.
  - The next instruction appears the cycle after that.
- Flush asserted in cycle N: valid=0 in N+1. The target instruction appears in N+2.
- Back-to-back flushes extend FLUSH, one bubble per flush cycle.
- Reset mid-HOLD or mid-FLUSH returns to BOOT at the next edge. held_instr is discarded.
- ADDRESS_BITS and DATA_WIDTH are fully parametric. No arithmetic is performed on the PC.

## Configuration
- FETCH_RECEIVE_PERF_EN defined:
  - Adds output port fetch_count (out, 32).
  - fetch_count increments at each edge where valid=1 and stall=0. It resets to 0 and wraps at 2^32.
- FETCH_RECEIVE_PERF_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then release, RESET_PC=0, memory returns 0x00000093 for address 0:
  - BOOT cycle shows NOP, valid=0.
  - Next cycle shows instruction=0x00000093, inst_PC=0, valid=1.
- Sequential fetch of addresses 0,4,8 with data A,B,C -> instruction/inst_PC follow A/0, B/4, C/8 on consecutive cycles.
- Stall for 3 cycles while B/4 is delivered and memory data changes to C -> B/4 is held for 4 cycles total, then C/8 follows.
- Flush while A/0 is delivered, target 0x40 with data T:
  - Next cycle: NOP, valid=0.
  - Cycle after: T/0x40.
- Flush and stall asserted together in HOLD -> FLUSH is entered and valid=0 next cycle.
- Reset asserted during HOLD -> BOOT outputs next cycle. With FETCH_RECEIVE_PERF_EN, fetch_count=0 and counts exactly the accepted instructions afterwards.
